microwave_timer_ctrl: RTL and testbench
=======================================

Name: microwave_timer_ctrl

Overview:
- Control FSM that sequences the microwave countdown datapath: the cascaded units/tens/minutes down-counters.
- Decodes the front-panel buttons and the door sensor, and drives the counter load, clear and enable controls.
- Gates the magnetron and sounds the end-of-cook beeper.
- Sits between the panel debouncers and the counter chain; consumes the chain's all-zero flag and an external 1 Hz strobe.

Parameters:
BEEP_TICKS, 3, number of 1 Hz ticks the beeper stays on in DONE (1..15)

Ports:
clk  input  1  system clock
clrn  input  1  asynchronous active-low reset
tick  input  1  one-clk-wide 1 Hz strobe from the prescaler
startn  input  1  start button, active-low, debounced level
stopn  input  1  stop/pause button, active-low, debounced level
setn  input  1  set-time button, active-low, debounced level (keypad value valid on data bus)
door_closed  input  1  1 = door latched
zero  input  1  counter chain reads 00:00 (combinational from chain)
cnt_loadn  output  1  active-low load strobe to the counter chain (chain loads keypad data)
cnt_clrn  output  1  active-low clear to the counter chain
cnt_en  output  1  count-down enable to the counter chain
mag_on  output  1  magnetron drive
beep  output  1  beeper drive
state  output  3  current FSM state code, for display logic

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on clrn. While clrn=0: state=IDLE, cnt_loadn=1, cnt_clrn=0, cnt_en=0, mag_on=0, beep=0, all edge-detect registers=1, beep counter=0.
- Button handling: each button is sampled into a register. A press event is a 1->0 transition between consecutive clk samples, which gives one event per press. Holding a button produces no repeats.
- Output registers: all outputs are registered except cnt_en.
- cnt_en is combinational: tick & (state==COOK) & door_closed & !zero.
- State codes: IDLE=0, READY=1, COOK=2, PAUSE=3, DONE=4. Codes 5-7 are illegal; the next state from any of them is IDLE.
- cnt_clrn:
  - Low for exactly one clk on entry to IDLE from PAUSE (stop pressed while paused).
  - Low for exactly one clk on entry to IDLE from READY (stop pressed).
  - Otherwise 1, except during reset.
- cnt_loadn: low for exactly one clk, in the cycle after a set event that is accepted in IDLE or READY.
- Transitions (registered; at most one per clk):
  - IDLE: set event -> READY with a load pulse. Start or stop events are ignored.
  - READY:
    - set event -> READY with a reload pulse.
    - start event with door_closed=1 and zero=0 -> COOK.
    - start event with door open or zero=1 -> stay in READY.
    - stop event -> IDLE with a clear pulse.
  - COOK:
    - door_closed=0 -> PAUSE immediately, same rule as stop.
    - stop event -> PAUSE.
    - zero=1 -> DONE.
    - set events are ignored.
  - PAUSE:
    - start event with door_closed=1 and zero=0 -> COOK.
    - stop event -> IDLE with a clear pulse.
    - set events are ignored.
  - DONE:
    - beep=1.
    - The beep counter increments on each tick. On the tick where the count reaches BEEP_TICKS -> IDLE, beep=0, counter=0.
    - A stop or start event -> IDLE immediately, beep=0.
    - Door-open has no effect.
- Priority on simultaneous events in the same clk: reset > door open > stop > start > set.
  - Example: start and stop in the same clk while in PAUSE -> IDLE.
- mag_on: registered, equals (next_state==COOK). It is 1 exactly in the cycles the FSM is in COOK. Door open drops mag_on in the cycle after door_closed falls; that one clk of latency is accepted.
- Counter/zero race:
  - If tick and zero=1 coincide in COOK, cnt_en=0, so the chain never wraps below 00:00.
  - The FSM moves to DONE on the first clk that zero=1 in COOK.
- Reset mid-cook: the asynchronous clrn drops mag_on and cnt_en immediately. The chain is not loaded again until a new set event.

Test Plan:
- Reset mid-cook: reset, set, then start, wait 2 ticks, pulse clrn low for 1 clk -> mag_on=0, cnt_en=0, state=0, cnt_clrn=0 while clrn=0; no loadn pulse afterwards until the next set.
- Normal cook: reset, set with chain loaded to 00:03, start with door closed -> state 0->1->2; cnt_loadn low 1 clk; mag_on=1; cnt_en=1 on 3 ticks; zero rises -> state=4, mag_on=0, beep=1 for 3 ticks, then state=0.
- Door interlock: in COOK, drop door_closed -> state=3 and mag_on=0 within 1 clk; start with door open -> stays in 3; close the door, then start -> state=2.
- Stop/clear: from PAUSE, stopn press -> state=0, cnt_clrn low exactly 1 clk. From READY, stopn press -> state=0, one cnt_clrn pulse.
- Start guards: in READY with zero=1, start -> stays in 1. Holding startn low for 50 clks -> exactly one start event. startn and stopn falling in the same clk in PAUSE -> state=0.
- Early beep cancel: in DONE, press stopn on the second beep tick -> state=0 and beep=0 next clk. A tick coincident with zero=1 in COOK -> cnt_en=0.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-cycle controller: decodes panel buttons and the door sensor, then sequences the countdown chain.
// Outputs are registered one cycle after the decision, except cnt_en, which is combinational.
module microwave_timer_ctrl #(
    parameter int BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       tick,
    input  logic       startn,
    input  logic       stopn,
    input  logic       setn,
    input  logic       door_closed,
    input  logic       zero,
    output logic       cnt_loadn,
    output logic       cnt_clrn,
    output logic       cnt_en,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS);

    state_t     state_q, state_d;
    logic       start_q, stop_q, set_q;
    logic [3:0] beep_cnt_q, beep_cnt_d;
    logic       loadn_q, loadn_d;
    logic       clrn_q, clrn_d;
    logic       mag_q, mag_d;
    logic       beep_q, beep_d;
    logic       start_ev, stop_ev, set_ev;
    logic       can_cook;

    // A press is a 1->0 step between the previous and current sample.
    assign start_ev = start_q & ~startn;
    assign stop_ev  = stop_q  & ~stopn;
    assign set_ev   = set_q   & ~setn;
    assign can_cook = door_closed & ~zero;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b1;
            stop_q     <= 1'b1;
            set_q      <= 1'b1;
            beep_cnt_q <= 4'd0;
            loadn_q    <= 1'b1;
            clrn_q     <= 1'b0;
            mag_q      <= 1'b0;
            beep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= startn;
            stop_q     <= stopn;
            set_q      <= setn;
            beep_cnt_q <= beep_cnt_d;
            loadn_q    <= loadn_d;
            clrn_q     <= clrn_d;
            mag_q      <= mag_d;
            beep_q     <= beep_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beep_cnt_d = 4'd0;
        loadn_d    = 1'b1;
        clrn_d     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (set_ev) begin
                    state_d = ST_READY;
                    loadn_d = 1'b0;
                end
            end
            ST_READY: begin
                if (stop_ev) begin
                    state_d = ST_IDLE;
                    clrn_d  = 1'b0;
                end else if (start_ev) begin
                    if (can_cook) state_d = ST_COOK;
                end else if (set_ev) begin
                    loadn_d = 1'b0;
                end
            end
            ST_COOK: begin
                if (!door_closed || stop_ev) state_d = ST_PAUSE;
                else if (zero)               state_d = ST_DONE;
            end
            ST_PAUSE: begin
                if (stop_ev) begin
                    state_d = ST_IDLE;
                    clrn_d  = 1'b0;
                end else if (start_ev && can_cook) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_ev || start_ev) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    // The final tick returns to IDLE with the counter cleared.
                    if (beep_cnt_q + 4'd1 >= BEEP_LAST) state_d = ST_IDLE;
                    else                                beep_cnt_d = beep_cnt_q + 4'd1;
                end else begin
                    beep_cnt_d = beep_cnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        mag_d  = (state_d == ST_COOK);
        beep_d = (state_d == ST_DONE);
    end

    // Gated by zero so the chain never wraps below 00:00.
    assign cnt_en    = tick & (state_q == ST_COOK) & door_closed & ~zero;
    assign cnt_loadn = loadn_q;
    assign cnt_clrn  = clrn_q;
    assign mag_on    = mag_q;
    assign beep      = beep_q;
    assign state     = state_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: a seconds-counting chain model drives zero, and a cook-cycle model predicts every output.
module tb_microwave_timer_ctrl;

    localparam int BEEPS = 3;
    localparam int M_IDLE = 0, M_READY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;

    logic       clk = 1'b0;
    logic       clrn, tick, startn, stopn, setn, door_closed, zero;
    logic       cnt_loadn, cnt_clrn, cnt_en, mag_on, beep;
    logic [2:0] state;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference: cook mode, beep ticks heard so far, last button levels, expected registered outputs.
    int   m_mode, m_beeps;
    logic m_last_start, m_last_stop, m_last_set;
    logic e_loadn, e_clrn;
    // Environment: the countdown chain in whole seconds, and the keypad value it loads.
    int   secs = 0;
    int   keypad = 3;

    microwave_timer_ctrl #(.BEEP_TICKS(BEEPS)) dut (
        .clk(clk), .clrn(clrn), .tick(tick), .startn(startn), .stopn(stopn),
        .setn(setn), .door_closed(door_closed), .zero(zero),
        .cnt_loadn(cnt_loadn), .cnt_clrn(cnt_clrn), .cnt_en(cnt_en),
        .mag_on(mag_on), .beep(beep), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".state"}, 8'(state), 8'(m_mode));
        chk({tag, ".mag_on"}, 8'(mag_on), 8'(m_mode == M_COOK));
        chk({tag, ".beep"}, 8'(beep), 8'(m_mode == M_DONE));
        chk({tag, ".loadn"}, 8'(cnt_loadn), 8'(e_loadn));
        chk({tag, ".clrn"}, 8'(cnt_clrn), 8'(e_clrn));
    endtask

    // Entered and left just after a falling clock edge.
    task automatic do_reset();
        clrn = 1'b0;
        #1;
        m_mode = M_IDLE; m_beeps = 0;
        m_last_start = 1'b1; m_last_stop = 1'b1; m_last_set = 1'b1;
        e_loadn = 1'b1; e_clrn = 1'b0;
        chk_regs("rst_async");
        chk("rst_async.cnt_en", 8'(cnt_en), 8'd0);
        @(posedge clk);
        secs = 0;
        #1;
        chk_regs("rst_hold");
        @(negedge clk);
        clrn = 1'b1;
    endtask

    // One clock of stimulus; the model applies the cook-cycle rules to this cycle's inputs.
    task automatic step(input logic s, input logic p, input logic t, input logic d, input logic tk);
        logic z, ld, cl, en, go, halt, arm;
        startn = s; stopn = p; setn = t; door_closed = d; tick = tk;
        z = (secs == 0);
        zero = z;
        #1;
        chk("cnt_en", 8'(cnt_en), 8'(tk && m_mode == M_COOK && d && !z));
        ld = cnt_loadn; cl = cnt_clrn; en = cnt_en;
        @(posedge clk);
        go   = m_last_start && !s;
        halt = m_last_stop && !p;
        arm  = m_last_set && !t;
        m_last_start = s; m_last_stop = p; m_last_set = t;
        e_loadn = 1'b1; e_clrn = 1'b1;
        if (m_mode == M_IDLE) begin
            if (arm) begin m_mode = M_READY; e_loadn = 1'b0; end
        end else if (m_mode == M_READY) begin
            if (halt) begin m_mode = M_IDLE; e_clrn = 1'b0; end
            else if (go) m_mode = (d && !z) ? M_COOK : M_READY;
            else if (arm) e_loadn = 1'b0;
        end else if (m_mode == M_COOK) begin
            if (!d || halt) m_mode = M_PAUSE;
            else if (z) begin m_mode = M_DONE; m_beeps = 0; end
        end else if (m_mode == M_PAUSE) begin
            if (halt) begin m_mode = M_IDLE; e_clrn = 1'b0; end
            else if (go && d && !z) m_mode = M_COOK;
        end else begin
            if (halt || go) m_mode = M_IDLE;
            else if (tk) begin
                m_beeps++;
                if (m_beeps == BEEPS) m_mode = M_IDLE;
            end
        end
        if (!cl) secs = 0;
        else if (!ld) secs = keypad;
        else if (en && secs > 0) secs--;
        #1;
        chk_regs("step");
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic tk);
        for (int i = 0; i < n; i++) step(1, 1, 1, 1, tk);
    endtask

    task automatic load_and_start(input int val);
        keypad = val;
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r_s, r_p, r_t, r_d;
        clrn = 1'b1; tick = 1'b0; startn = 1'b1; stopn = 1'b1; setn = 1'b1;
        door_closed = 1'b1; zero = 1'b1;
        @(negedge clk);
        do_reset();

        // Full cook of three seconds, then three beep ticks back to idle.
        load_and_start(3);
        chk("cook_entered", 8'(state), 8'(M_COOK));
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 1);
        chk("done_entered", 8'(state), 8'(M_DONE));
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1);
        chk("done_expired", 8'(state), 8'(M_IDLE));
        idle(2, 0);

        // Door interlock.
        load_and_start(5);
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 0, 0);
        chk("door_pause", 8'(state), 8'(M_PAUSE));
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        chk("door_resume", 8'(state), 8'(M_COOK));
        step(1, 1, 1, 1, 0);

        // Stop to pause, stop again to clear; then stop from READY.
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        chk("pause_stop_clr", 8'(cnt_clrn), 8'd0);
        step(1, 1, 1, 1, 0);
        keypad = 4;
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        chk("ready_stop", 8'(state), 8'(M_IDLE));
        step(1, 1, 1, 1, 0);

        // Start refused while the chain reads zero.
        keypad = 0;
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        chk("zero_guard", 8'(state), 8'(M_READY));
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);

        // A held start yields one event; start+stop together in PAUSE go idle.
        keypad = 5;
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        for (int i = 0; i < 48; i++) step(0, 1, 1, 1, 0);
        chk("hold_no_repeat", 8'(state), 8'(M_PAUSE));
        step(1, 1, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("start_stop_same", 8'(state), 8'(M_IDLE));
        step(1, 1, 1, 1, 0);

        // Stop on the second beep tick cancels the beeper.
        load_and_start(1);
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1);
        step(1, 0, 1, 1, 1);
        chk("early_cancel", 8'(beep), 8'd0);
        step(1, 1, 1, 1, 0);

        // Reset mid-cook; no reload until the next set press.
        load_and_start(5);
        step(1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 0);
        step(1, 1, 1, 1, 1);
        do_reset();
        idle(5, 1);
        step(1, 1, 0, 1, 0);
        chk("reload_after_rst", 8'(cnt_loadn), 8'd0);
        step(1, 1, 1, 1, 0);

        // Random panel activity.
        r_s = 1; r_p = 1; r_t = 1; r_d = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) r_s = ~r_s;
            if ($urandom_range(0, 29) == 0) r_p = ~r_p;
            if ($urandom_range(0, 14) == 0) r_t = ~r_t;
            if (r_d ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0)) r_d = ~r_d;
            keypad = $urandom_range(0, 4);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(r_s, r_p, r_t, r_d, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
